pipe_pal_infifo: RTL and testbench
==================================

Name: pipe_pal_infifo

Overview:
- Input buffer that sits directly upstream of the pipe_pal stage and feeds its W_DATA-wide data input.
- Decouples the producer from pipe_pal with a DEPTH-entry first-word-fall-through FIFO using valid/ready handshakes on both sides.
- Provides an occupancy count and a synchronous flush.
- Register-based storage; no RAM macro.

Parameters:
- W_DATA, 32, payload width; matches the pipe_pal data input.
- DEPTH, 4, number of entries; power of two, at least 2.
- W_ADDR (localparam), $clog2(DEPTH), storage index width.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- resetn  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously with i_clk.
- i_flush  input  1  synchronous flush; discards all entries.
- s_valid  input  1  producer has data.
- s_ready  output  1  FIFO can accept data.
- s_data  input  W_DATA  producer payload.
- m_valid  output  1  head entry available to pipe_pal.
- m_ready  input  1  pipe_pal accepts the head entry.
- m_data  output  W_DATA  head entry payload.
- o_count  output  W_ADDR+1  number of stored entries, 0..DEPTH.

Behaviour:
- Handshakes:
  - Push occurs when s_valid && s_ready on a rising edge of i_clk.
  - Pop occurs when m_valid && m_ready on a rising edge of i_clk.
- Pointers:
  - wr_ptr and rd_ptr are each W_ADDR+1 bits and wrap modulo 2*DEPTH.
  - The low W_ADDR bits index storage.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits are equal.
- Outputs:
  - o_count = wr_ptr - rd_ptr, computed modulo 2^(W_ADDR+1). It is always registered-state derived and never depends combinationally on inputs.
  - s_ready = !full && resetn. It does not depend on m_ready, so there is no comb path from m_ready to s_ready. When full, a simultaneous pop does not allow a push that cycle.
  - m_valid = !empty.
  - m_data = storage[rd_ptr low bits]; its value is don't-care when m_valid = 0.
- Latency:
  - A word pushed at edge N is visible on m_valid/m_data after edge N (one-cycle latency).
  - There is no same-cycle bypass when empty.
- Simultaneous push and pop (not full, not empty): both pointers advance and o_count is unchanged.
- Push while empty with m_ready high: only the push takes effect, because m_valid was 0.
- Flush:
  - When i_flush = 1 at an edge, wr_ptr and rd_ptr are set to 0, o_count becomes 0, and m_valid goes low the next cycle.
  - Any push or pop in the same cycle is ignored, including a handshake that looks complete on the ports. The producer must not count that word as delivered.
- Reset values (asynchronous, while resetn = 0):
  - wr_ptr = 0, rd_ptr = 0.
  - o_count = 0, m_valid = 0, s_ready = 0.
  - Storage is not reset.
- Reset asserted mid-transfer: all stored entries are lost. s_ready and m_valid drop in the same cycle, without waiting for a clock.
- Ordering: strict FIFO order. No entry is duplicated or dropped except by flush or reset.
- No overflow or underflow is possible: both are prevented by s_ready and m_valid gating.

Decomposition:
- Shared package pipe_pal_pkg:
  - W_DATA default constant.
  - Payload typedef logic [W_DATA-1:0] data_t, shared with pipe_pal.
- Single natural sub-module: pipe_pal_ptr, a W_ADDR+1 wrapping pointer register with increment enable, synchronous clear and asynchronous active-low reset. It is instantiated twice (write and read).
- Storage and flag logic stay in the top module.

Test Plan:
1. Reset then idle: resetn low for 3 cycles -> m_valid=0, s_ready=0, o_count=0 during reset. After release: s_ready=1, m_valid=0.
2. Fill and drain, DEPTH=4, m_ready=0: push 0x11, 0x22, 0x33, 0x44 -> o_count steps 1..4, s_ready=0 after the 4th push. Then set m_ready=1 -> m_data reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles, and m_valid=0 after.
3. Full with simultaneous pop: at o_count=4, s_valid=1 and m_ready=1 -> one pop and no push, o_count=3. On the next cycle the push is accepted, o_count=3 again, with the new word at the tail.
4. Streaming wrap-around: s_valid=1 and m_ready=1 continuously for 20 words 0..19 -> o_count stays 1 after the first cycle, output order is 0..19, and pointers wrap past 2*DEPTH with no loss.
5. Flush collision: o_count=3 and i_flush=1 with s_valid=1 and m_ready=1 in the same cycle -> next cycle o_count=0 and m_valid=0. The next pushed word 0xAB is the first word out.
6. Async reset mid-stream: resetn pulled low between clock edges while o_count=2 -> m_valid and s_ready fall without a clock edge. After release, o_count=0.

Source files
------------

// File: rtl/pipe_pal_pkg.sv
// Shared definitions for the pipe_pal stage and the blocks around it.
//   W_DATA_DEFAULT : default payload width of the pipe_pal data input
//   data_t         : payload type at the default width
package pipe_pal_pkg;

    localparam int W_DATA_DEFAULT = 32;

    typedef logic [W_DATA_DEFAULT-1:0] data_t;

endpackage : pipe_pal_pkg

// File: rtl/pipe_pal_infifo_if.sv
// Producer/consumer handshake bundle around the pipe_pal input FIFO.
//   s_valid/s_ready/s_data : producer -> FIFO
//   m_valid/m_ready/m_data : FIFO -> pipe_pal
// Handshake rule on both sides: a transfer happens on a rising clock edge
// exactly when valid && ready are both high; valid must not wait for ready,
// and the data is held stable while valid is high and ready is low.
//   modport slave  : the FIFO's view (accepts on s_*, offers on m_*)
//   modport master : the environment's view (drives s_*, consumes m_*)
interface pipe_pal_infifo_if
    import pipe_pal_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEFAULT
);
    logic              s_valid;
    logic              s_ready;
    logic [W_DATA-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [W_DATA-1:0] m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface : pipe_pal_infifo_if

// File: rtl/pipe_pal_ptr.sv
// Wrapping pointer register for the pipe_pal input FIFO.
//   i_clk  : clock
//   resetn : asynchronous active-low reset (pointer -> 0)
//   i_clr  : synchronous clear, wins over i_inc
//   i_inc  : advance by one, wrapping modulo 2^W
//   o_ptr  : current pointer value
module pipe_pal_ptr #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         resetn,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);
    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (i_clr) begin
            ptr_d = '0;
        end else if (i_inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;
endmodule : pipe_pal_ptr

// File: rtl/pipe_pal_infifo.sv
// First-word-fall-through input buffer in front of pipe_pal.
//   i_clk   : clock
//   resetn  : asynchronous active-low reset; empties the FIFO
//   i_flush : synchronous flush; discards all entries and any same-cycle push/pop
//   bus     : slave side of pipe_pal_infifo_if (s_* from producer, m_* to pipe_pal)
//   o_count : stored entries, 0..DEPTH
module pipe_pal_infifo
    import pipe_pal_pkg::*;
#(
    parameter int W_DATA = W_DATA_DEFAULT,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     resetn,
    input  logic                     i_flush,
    pipe_pal_infifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int W_ADDR = $clog2(DEPTH);

    logic [W_DATA-1:0] mem_q [DEPTH];
    logic [W_DATA-1:0] mem_d [DEPTH];

    logic [W_ADDR:0] wr_ptr;
    logic [W_ADDR:0] rd_ptr;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[W_ADDR] != rd_ptr[W_ADDR]) &&
                   (wr_ptr[W_ADDR-1:0] == rd_ptr[W_ADDR-1:0]);

    // s_ready looks only at stored state (and reset), never at m_ready, so a
    // full FIFO refuses a push even in a cycle where it is popping.
    assign bus.s_ready = !full && resetn;
    assign bus.m_valid = !empty;
    assign bus.m_data  = mem_q[rd_ptr[W_ADDR-1:0]];
    assign o_count     = wr_ptr - rd_ptr;

    // A flush swallows any handshake that looks complete on the ports.
    assign push = bus.s_valid && bus.s_ready && !i_flush;
    assign pop  = bus.m_valid && bus.m_ready && !i_flush;

    pipe_pal_ptr #(.W(W_ADDR + 1)) u_wr_ptr (
        .i_clk  (i_clk),
        .resetn (resetn),
        .i_clr  (i_flush),
        .i_inc  (push),
        .o_ptr  (wr_ptr)
    );

    pipe_pal_ptr #(.W(W_ADDR + 1)) u_rd_ptr (
        .i_clk  (i_clk),
        .resetn (resetn),
        .i_clr  (i_flush),
        .i_inc  (pop),
        .o_ptr  (rd_ptr)
    );

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr[W_ADDR-1:0]] = bus.s_data;
        end
    end

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end
endmodule : pipe_pal_infifo

// File: tb/tb_pipe_pal_infifo.sv
module tb_pipe_pal_infifo;
    import pipe_pal_pkg::*;

    localparam int DEPTH  = 4;
    localparam int W_CNT  = $clog2(DEPTH) + 1;

    logic             i_clk;
    logic             resetn;
    logic             i_flush;
    logic [W_CNT-1:0] o_count;

    pipe_pal_infifo_if #(.W_DATA(W_DATA_DEFAULT)) bus ();

    pipe_pal_infifo #(.W_DATA(W_DATA_DEFAULT), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .resetn  (resetn),
        .i_flush (i_flush),
        .bus     (bus.slave),
        .o_count (o_count)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic       flush;
        logic       s_valid;
        data_t      s_data;
        logic       m_ready;
        logic       exp_s_ready;
        logic       exp_m_valid;
        data_t      exp_m_data;   // checked only when exp_m_valid
        int         exp_count;
    } vec_t;

    vec_t vecs[$];

    int n_vec;
    int n_err;

    function automatic void add(logic fl, logic sv, data_t sd, logic mr,
                                logic esr, logic emv, data_t emd, int ecnt);
        vec_t v;
        v.flush = fl; v.s_valid = sv; v.s_data = sd; v.m_ready = mr;
        v.exp_s_ready = esr; v.exp_m_valid = emv; v.exp_m_data = emd;
        v.exp_count = ecnt;
        vecs.push_back(v);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic esr, input logic emv,
                                 input data_t emd, input int ecnt);
        check({tag, ".s_ready"}, 32'(bus.s_ready), 32'(esr));
        check({tag, ".m_valid"}, 32'(bus.m_valid), 32'(emv));
        check({tag, ".o_count"}, 32'(o_count), 32'(ecnt));
        if (emv) check({tag, ".m_data"}, bus.m_data, emd);
    endtask

    // ---------------- driver ----------------
    // Inputs are driven 1 time unit after a rising edge; outputs are sampled
    // 1 time unit after the following rising edge.
    task automatic drive(input logic fl, input logic sv, input data_t sd, input logic mr);
        i_flush     = fl;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.m_ready = mr;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_flush = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        idle_inputs();

        // Fill and drain with m_ready low, then high.
        add(0, 1, 'h11, 0,  1, 1, 'h11, 1);
        add(0, 1, 'h22, 0,  1, 1, 'h11, 2);
        add(0, 1, 'h33, 0,  1, 1, 'h11, 3);
        add(0, 1, 'h44, 0,  0, 1, 'h11, 4);
        add(0, 1, 'hEE, 0,  0, 1, 'h11, 4);   // refused: full
        add(0, 0, 'h00, 1,  1, 1, 'h22, 3);
        add(0, 0, 'h00, 1,  1, 1, 'h33, 2);
        add(0, 0, 'h00, 1,  1, 1, 'h44, 1);
        add(0, 0, 'h00, 1,  1, 0, 'h00, 0);
        add(0, 0, 'h00, 1,  1, 0, 'h00, 0);   // pop on empty does nothing
        // Full with simultaneous pop: no push that cycle.
        add(0, 1, 'h51, 0,  1, 1, 'h51, 1);
        add(0, 1, 'h52, 0,  1, 1, 'h51, 2);
        add(0, 1, 'h53, 0,  1, 1, 'h51, 3);
        add(0, 1, 'h54, 0,  0, 1, 'h51, 4);
        add(0, 1, 'h55, 1,  1, 1, 'h52, 3);   // pop only
        add(0, 1, 'h55, 1,  1, 1, 'h53, 3);   // push + pop
        add(0, 0, 'h00, 1,  1, 1, 'h54, 2);
        add(0, 0, 'h00, 1,  1, 1, 'h55, 1);
        add(0, 0, 'h00, 1,  1, 0, 'h00, 0);
        // Push while empty with m_ready high: push only.
        add(0, 1, 'h5A, 1,  1, 1, 'h5A, 1);
        add(0, 0, 'h00, 1,  1, 0, 'h00, 0);
        // Flush collision.
        add(0, 1, 'h61, 0,  1, 1, 'h61, 1);
        add(0, 1, 'h62, 0,  1, 1, 'h61, 2);
        add(0, 1, 'h63, 0,  1, 1, 'h61, 3);
        add(1, 1, 'h99, 1,  1, 0, 'h00, 0);
        add(0, 1, 'hAB, 0,  1, 1, 'hAB, 1);
        add(0, 0, 'h00, 1,  1, 0, 'h00, 0);

        // Reset then idle: outputs held low during reset.
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk);
            #1;
            check_outputs("reset", 1'b0, 1'b0, '0, 0);
        end
        @(negedge i_clk);
        resetn = 1'b1;
        @(posedge i_clk);
        #1;
        check_outputs("post_reset", 1'b1, 1'b0, '0, 0);

        // Table vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].s_valid, vecs[i].s_data, vecs[i].m_ready);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_s_ready,
                          vecs[i].exp_m_valid, vecs[i].exp_m_data, vecs[i].exp_count);
        end

        // Streaming wrap-around: 20 words, pointers wrap several times.
        begin
            logic [31:0] exp_q[$];
            data_t       exp_w;
            for (int w = 0; w < 20; w++) begin
                exp_q.push_back(32'(w));
                drive(1'b0, 1'b1, data_t'(w), 1'b1);
                if (w > 0) void'(exp_q.pop_front());
                exp_w = exp_q[0];
                check_outputs($sformatf("stream%0d", w), 1'b1, 1'b1, exp_w, 1);
            end
            drive(1'b0, 1'b0, '0, 1'b1);
            check_outputs("stream_end", 1'b1, 1'b0, '0, 0);
        end

        // Asynchronous reset mid-stream with two entries held.
        drive(1'b0, 1'b1, 'h71, 1'b0);
        drive(1'b0, 1'b1, 'h72, 1'b0);
        check_outputs("pre_areset", 1'b1, 1'b1, 'h71, 2);
        idle_inputs();
        #2;
        resetn = 1'b0;
        #1;   // still well before the next rising edge
        check_outputs("areset_noclk", 1'b0, 1'b0, '0, 0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        resetn = 1'b1;
        @(posedge i_clk);
        #1;
        check_outputs("areset_release", 1'b1, 1'b0, '0, 0);
        drive(1'b0, 1'b1, 'h81, 1'b0);
        check_outputs("areset_first", 1'b1, 1'b1, 'h81, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule : tb_pipe_pal_infifo
